// File: rtl/intdiv_sched.sv
// Round-robin scheduler sharing one pipelined signed divider among NREQ requesters.
// A tag pipeline matched to the divider latency steers each result to its response slot.
module intdiv_sched #(
    parameter int unsigned N       = 4,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_x,
    input  logic [NREQ*N-1:0] req_y,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [NREQ*N-1:0] rsp_z,
    output logic [NREQ*N-1:0] rsp_r,
    output logic [NREQ-1:0]   rsp_dz,
    output logic [N-1:0]      div_x,
    output logic [N-1:0]      div_y,
    input  logic [N-1:0]      div_z,
    input  logic [N-1:0]      div_r,
    output logic              busy
);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           dz;
        logic [N-1:0]   x;
    } tag_t;

    logic [NREQ-1:0]   pending_q, pending_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0]   rsp_dz_q, rsp_dz_d;
    logic [NREQ*N-1:0] rsp_z_q, rsp_z_d;
    logic [NREQ*N-1:0] rsp_r_q, rsp_r_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    tag_t              tag_q [LATENCY];
    tag_t              tag_d [LATENCY];

    logic [NREQ-1:0]   eligible;
    logic              grant_vld;
    logic [IDW-1:0]    grant_id;
    tag_t              tail;

    // Round-robin scan starting at the pointer, wrapping at NREQ.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        eligible  = req_valid & ~pending_q & ~rsp_valid_q;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        div_x     = '0;
        div_y     = '0;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
            div_x = req_x[32'(grant_id)*N +: N];
            div_y = req_y[32'(grant_id)*N +: N];
        end
    end

    assign tail = tag_q[LATENCY-1];

    always_comb begin
        pending_d   = pending_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_dz_d    = rsp_dz_q & ~(rsp_valid_q & rsp_ready);
        rsp_z_d     = rsp_z_q;
        rsp_r_d     = rsp_r_q;
        ptr_d       = ptr_q;

        if (tail.vld) begin
            rsp_valid_d[tail.id] = 1'b1;
            pending_d[tail.id]   = 1'b0;
            if (tail.dz) begin
                // Divider output is meaningless for y==0; report -1 and the dividend.
                rsp_z_d[32'(tail.id)*N +: N] = {N{1'b1}};
                rsp_r_d[32'(tail.id)*N +: N] = tail.x;
                rsp_dz_d[tail.id]            = 1'b1;
            end else begin
                rsp_z_d[32'(tail.id)*N +: N] = div_z;
                rsp_r_d[32'(tail.id)*N +: N] = div_r;
                rsp_dz_d[tail.id]            = 1'b0;
            end
        end

        if (grant_vld) begin
            pending_d[grant_id] = 1'b1;
            if (32'(grant_id) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id + IDW'(1);
            end
        end

        tag_d[0].vld = grant_vld;
        tag_d[0].id  = grant_id;
        tag_d[0].dz  = grant_vld && (div_y == '0);
        tag_d[0].x   = div_x;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            rsp_valid_q <= '0;
            rsp_dz_q    <= '0;
            rsp_z_q     <= '0;
            rsp_r_q     <= '0;
            ptr_q       <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dz_q    <= rsp_dz_d;
            rsp_z_q     <= rsp_z_d;
            rsp_r_q     <= rsp_r_d;
            ptr_q       <= ptr_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_comb begin
        busy = (|pending_q) | (|rsp_valid_q);
        for (int unsigned i = 0; i < LATENCY; i++) begin
            busy = busy | tag_q[i].vld;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_dz    = rsp_dz_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_r     = rsp_r_q;

endmodule

// File: tb/tb_intdiv_sched.sv
// Bench for intdiv_sched: behavioural pipelined divider, issue/capture scoreboard,
// and one task per scenario.
module tb_intdiv_sched;

    localparam int N    = 4;
    localparam int NREQ = 2;
    localparam int LAT  = 4;

    logic              clock;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*N-1:0] req_x, req_y;
    logic [NREQ-1:0]   rsp_valid, rsp_ready, rsp_dz;
    logic [NREQ*N-1:0] rsp_z, rsp_r;
    logic [N-1:0]      div_x, div_y, div_z, div_r;
    logic              busy;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        int           id;
        logic [N-1:0] z;
        logic [N-1:0] r;
        logic         dz;
        int           icyc;
    } exp_t;

    exp_t exp_q[$];

    intdiv_sched #(.N(N), .NREQ(NREQ), .LATENCY(LAT), .IDW(1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_r     (rsp_r),
        .rsp_dz    (rsp_dz),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_z     (div_z),
        .div_r     (div_r),
        .busy      (busy)
    );

    function automatic logic [N-1:0] model_quo(input logic [N-1:0] x, input logic [N-1:0] y);
        int xi;
        int yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        if (yi == 0) return '0;
        return N'(xi / yi);
    endfunction

    function automatic logic [N-1:0] model_rem(input logic [N-1:0] x, input logic [N-1:0] y);
        int xi;
        int yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        if (yi == 0) return '0;
        return N'(xi % yi);
    endfunction

    // Divider stand-in: result visible LAT edges after the sampling edge, no reset.
    logic [N-1:0] q_pipe [LAT];
    logic [N-1:0] r_pipe [LAT];
    always @(posedge clock) begin
        q_pipe[0] <= model_quo(div_x, div_y);
        r_pipe[0] <= model_rem(div_x, div_y);
        for (int i = 1; i < LAT; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            r_pipe[i] <= r_pipe[i-1];
        end
    end
    assign div_z = q_pipe[LAT-1];
    assign div_r = r_pipe[LAT-1];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: push on issue handshake, pop on each new rsp_valid.
    initial begin
        logic [NREQ-1:0] prev_rv;
        logic [NREQ-1:0] hs;
        logic [NREQ-1:0] rise;
        logic [N-1:0]    ex, ey;
        exp_t            e;
        int              g;
        prev_rv = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_q.delete();
                prev_rv = '0;
            end else begin
                checks++;
                if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                    errors++;
                    $display("FAIL grant_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
                end
                hs = req_valid & req_ready;
                if (hs != '0) begin
                    g = 0;
                    for (int i = NREQ - 1; i >= 0; i--) if (hs[i]) g = i;
                    ex     = req_x[g*N +: N];
                    ey     = req_y[g*N +: N];
                    e.id   = g;
                    e.dz   = (ey == '0);
                    e.z    = e.dz ? '1 : model_quo(ex, ey);
                    e.r    = e.dz ? ex : model_rem(ex, ey);
                    e.icyc = cyc;
                    exp_q.push_back(e);
                    checks++;
                    if (div_x !== ex || div_y !== ey) begin
                        errors++;
                        $display("FAIL div_operands: got x=%h y=%h expected x=%h y=%h",
                                 div_x, div_y, ex, ey);
                    end
                end
                rise = rsp_valid & ~prev_rv;
                for (int i = 0; i < NREQ; i++) begin
                    if (rise[i]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_rsp: requester %0d z=%h r=%h", i,
                                     rsp_z[i*N +: N], rsp_r[i*N +: N]);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.id != i || rsp_z[i*N +: N] !== e.z || rsp_r[i*N +: N] !== e.r
                                || rsp_dz[i] !== e.dz || cyc != e.icyc + LAT + 1) begin
                                errors++;
                                $display("FAIL rsp_data: got id=%0d z=%h r=%h dz=%b cyc=%0d expected id=%0d z=%h r=%h dz=%b cyc=%0d",
                                         i, rsp_z[i*N +: N], rsp_r[i*N +: N], rsp_dz[i], cyc,
                                         e.id, e.z, e.r, e.dz, e.icyc + LAT + 1);
                            end
                        end
                    end
                end
                prev_rv = rsp_valid;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        rsp_ready = '1;
        req_valid = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (!busy) break;
            step();
        end
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (rsp_valid !== '0 || rsp_dz !== '0 || rsp_z !== '0 || rsp_r !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b dz=%b z=%h r=%h expected all zero",
                     rsp_valid, rsp_dz, rsp_z, rsp_r);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== '0 || div_x !== '0 || div_y !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b ready=%b dx=%h dy=%h expected zero",
                     busy, req_ready, div_x, div_y);
        end
    endtask

    task automatic test_single();
        req_x[3:0] = 4'd7;
        req_y[3:0] = 4'd3;
        req_valid  = 2'b01;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01 || div_x !== 4'd7 || div_y !== 4'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: got ready=%b dx=%h dy=%h busy=%b expected 01 7 3 0",
                     req_ready, div_x, div_y, busy);
        end
        step();
        req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b1 || rsp_valid[0] !== (c == 5)) begin
                errors++;
                $display("FAIL single_timing: cycle %0d got busy=%b v0=%b expected 1 %b",
                         c, busy, rsp_valid[0], (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (rsp_z[3:0] !== 4'd2 || rsp_r[3:0] !== 4'd1 || rsp_dz[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_result: got z=%h r=%h dz=%b expected 2 1 0",
                             rsp_z[3:0], rsp_r[3:0], rsp_dz[0]);
                end
            end
            step();
        end
        rsp_ready = 2'b01;
        @(negedge clock);
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL single_hold: got v=%b expected 01", rsp_valid);
        end
        step();
        rsp_ready = '0;
        @(negedge clock);
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_z[3:0] !== 4'd2) begin
            errors++;
            $display("FAIL single_consume: got v=%b busy=%b z=%h expected 00 0 2",
                     rsp_valid, busy, rsp_z[3:0]);
        end
        step();
    endtask

    task automatic test_contention();
        req_x     = {4'd5, 4'd6};
        req_y     = {4'd3, 4'd2};
        req_valid = 2'b11;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL cont_grant0: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b10;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL cont_grant1: got %b expected 10", req_ready);
        end
        step();
        req_valid  = 2'b01;
        req_x[3:0] = 4'd1;
        req_y[3:0] = 4'd1;
        for (int c = 2; c <= 7; c++) begin
            if (c == 7) rsp_ready = 2'b11;
            @(negedge clock);
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL cont_blocked: cycle %0d got %b expected 00", c, req_ready);
            end
            if (c == 5) begin
                checks++;
                if (rsp_valid !== 2'b01 || rsp_z[3:0] !== 4'd3 || rsp_r[3:0] !== 4'd0) begin
                    errors++;
                    $display("FAIL cont_rsp0: got v=%b z=%h r=%h expected 01 3 0",
                             rsp_valid, rsp_z[3:0], rsp_r[3:0]);
                end
            end
            if (c == 6) begin
                checks++;
                if (rsp_valid !== 2'b11 || rsp_z[7:4] !== 4'd1 || rsp_r[7:4] !== 4'd2) begin
                    errors++;
                    $display("FAIL cont_rsp1: got v=%b z=%h r=%h expected 11 1 2",
                             rsp_valid, rsp_z[7:4], rsp_r[7:4]);
                end
            end
            step();
        end
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL cont_regrant: got %b expected 01", req_ready);
        end
        step();
        wait_idle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_div_zero();
        req_x[7:4] = 4'hB;
        req_y[7:4] = 4'h0;
        req_valid  = 2'b10;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL dz_grant: got %b expected 10", req_ready);
        end
        step();
        req_valid = '0;
        repeat (4) step();
        @(negedge clock);
        checks++;
        if (rsp_valid !== 2'b10 || rsp_dz !== 2'b10 || rsp_z[7:4] !== 4'hF
            || rsp_r[7:4] !== 4'hB) begin
            errors++;
            $display("FAIL dz_result: got v=%b dz=%b z=%h r=%h expected 10 10 F B",
                     rsp_valid, rsp_dz, rsp_z[7:4], rsp_r[7:4]);
        end
        step();
        rsp_ready = 2'b11;
        step();
        @(negedge clock);
        checks++;
        if (rsp_valid !== '0 || rsp_dz !== '0 || rsp_z[7:4] !== 4'hF) begin
            errors++;
            $display("FAIL dz_consume: got v=%b dz=%b z=%h expected 00 00 F",
                     rsp_valid, rsp_dz, rsp_z[7:4]);
        end
        step();
    endtask

    task automatic test_negative();
        logic [NREQ-1:0] g;
        req_x     = {4'h8, 4'h9};
        req_y     = {4'hF, 4'h2};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            g = req_valid & req_ready;
            step();
            req_valid = req_valid & ~g;
        end
        wait_idle();
        checks++;
        if (busy !== 1'b0 || rsp_z[3:0] !== 4'hD || rsp_r[3:0] !== 4'hF) begin
            errors++;
            $display("FAIL neg_result0: got busy=%b z=%h r=%h expected 0 D F",
                     busy, rsp_z[3:0], rsp_r[3:0]);
        end
        checks++;
        if (rsp_z[7:4] !== 4'h8 || rsp_r[7:4] !== 4'h0) begin
            errors++;
            $display("FAIL neg_minint: got z=%h r=%h expected 8 0", rsp_z[7:4], rsp_r[7:4]);
        end
    endtask

    task automatic test_back_pressure();
        logic [NREQ-1:0] g;
        logic            seen1;
        req_x[3:0] = 4'd7;
        req_y[3:0] = 4'd2;
        req_valid  = 2'b01;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 01", req_ready);
        end
        step();
        req_valid = '0;
        repeat (4) step();
        req_x     = {4'd3, 4'd4};
        req_y     = {4'd1, 4'd2};
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        seen1     = 1'b0;
        for (int c = 5; c < 15; c++) begin
            @(negedge clock);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_z[3:0] !== 4'd3 || rsp_r[3:0] !== 4'd1
                || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got v0=%b z=%h r=%h rdy0=%b expected 1 3 1 0",
                         c, rsp_valid[0], rsp_z[3:0], rsp_r[3:0], req_ready[0]);
            end
            g = req_valid & req_ready;
            if (g[1]) seen1 = 1'b1;
            step();
            req_valid = req_valid & ~g;
        end
        checks++;
        if (seen1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_served: got %b expected 1", seen1);
        end
        rsp_ready = 2'b11;
        @(negedge clock);
        step();
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01 || rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_regrant: got ready=%b v0=%b expected 01 0", req_ready, rsp_valid[0]);
        end
        step();
        wait_idle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] g;
        int              grants;
        grants = 0;
        for (int c = 0; c < 60; c++) begin
            rsp_ready = 2'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_x[i*N +: N] = 4'($urandom_range(0, 15));
                    req_y[i*N +: N] = ($urandom_range(0, 6) == 0) ? 4'd0
                                                                  : 4'($urandom_range(0, 15));
                    req_valid[i] = 1'b1;
                end
            end
            @(negedge clock);
            g = req_valid & req_ready;
            if (g != '0) grants++;
            step();
            req_valid = req_valid & ~g;
        end
        wait_idle();
        checks++;
        if (grants < 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_progress: got grants=%0d busy=%b expected >=8 and 0", grants, busy);
        end
    endtask

    task automatic test_reset_mid();
        req_x[3:0] = 4'd7;
        req_y[3:0] = 4'd3;
        req_valid  = 2'b01;
        rsp_ready  = 2'b11;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_grant: got %b expected 01", req_ready);
        end
        step();
        req_valid = '0;
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_z !== '0 || rsp_r !== '0) begin
            errors++;
            $display("FAIL rmid_async: got v=%b busy=%b z=%h r=%h expected zero",
                     rsp_valid, busy, rsp_z, rsp_r);
        end
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rmid_ghost: cycle %0d got v=%b busy=%b expected 00 0",
                         c, rsp_valid, busy);
            end
            step();
        end
        req_x     = {4'd2, 4'd1};
        req_y     = {4'd1, 4'd1};
        req_valid = 2'b11;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_pointer: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b10;
        @(negedge clock);
        step();
        wait_idle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_drain: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '0;
        test_reset();
        apply_reset();
        test_single();
        apply_reset();
        test_contention();
        apply_reset();
        test_div_zero();
        apply_reset();
        test_negative();
        apply_reset();
        test_back_pressure();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
